fifo_rd_serializer: RTL and testbench

- Drains a synchronous FIFO through its pop side: fifo_pndng, fifo_pop and fifo_dout.
- Each BITS-wide word is serialized into OUT_W-wide beats on a valid/ready output stream, least-significant beat first.
- Sits between a FIFO instance and a narrow downstream link or consumer.
- Sustains full throughput: no bubble between consecutive words while the FIFO has data pending.

---
 rtl/fifo_rd_serializer.sv | 87 ++++++++
 tb/tb_fifo_rd_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_serializer.sv
// Pops BITS-wide words from a synchronous FIFO and streams them out as
// OUT_W-wide valid/ready beats, least-significant beat first, with no bubble between words.
//
// state | meaning
// ------+---------------------------------------------------------
// EMPTY | no word held; pop as soon as the FIFO reports data
// SHIFT | word held in shreg; beats presented on out_data
module fifo_rd_serializer #(
    parameter int BITS  = 32,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_pndng,
    input  logic [BITS-1:0]  fifo_dout,
    output logic             fifo_pop,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    localparam int BEATS = BITS / OUT_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);

    generate
        if ((OUT_W <= 0) || (BITS < OUT_W) || (BITS % OUT_W != 0)) begin : g_bad_width
            $error("fifo_rd_serializer: BITS must be a positive integer multiple of OUT_W");
        end
    endgenerate

    logic [0:0]      state;
    logic [BITS-1:0] shreg;
    logic [CW-1:0]   cnt;

    logic loaded;
    logic accept;
    logic word_done;

    assign loaded    = (state == SHIFT);
    assign out_valid = loaded;
    assign out_data  = shreg[OUT_W-1:0];
    assign out_last  = loaded && (cnt == CNT_LAST);
    assign busy      = loaded;

    assign accept    = out_valid && out_ready;
    assign word_done = accept && out_last;

    // Combinational through out_ready so the next word loads on the edge the last beat leaves.
    assign fifo_pop  = !rst && fifo_pndng && (!loaded || word_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            shreg <= '0;
            cnt   <= '0;
        end else if (fifo_pop) begin
            state <= SHIFT;
            shreg <= fifo_dout;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= shreg >> OUT_W;
            if (out_last) begin
                state <= EMPTY;
                cnt   <= '0;
            end else begin
                cnt   <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (word_done) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench for fifo_rd_serializer: byte-wide default build plus a
// full-width (one beat per word) build, each fed by a small FIFO model.
module tb_fifo_rd_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_ready = 1'b0;

    // byte-wide instance and its FIFO model
    logic [31:0] mem [0:15];
    int          rd, wr;
    logic        fifo_pndng;
    logic [31:0] fifo_dout;
    logic        fifo_pop;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic [15:0] word_cnt;

    // full-width instance and its FIFO model
    logic [31:0] mem32 [0:15];
    int          rd32, wr32;
    logic        fifo_pndng32;
    logic [31:0] fifo_dout32;
    logic        fifo_pop32;
    logic        out_valid32;
    logic [31:0] out_data32;
    logic        out_last32;
    logic        busy32;
    logic [15:0] word_cnt32;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign fifo_pndng   = (rd < wr);
    assign fifo_dout    = mem[rd[3:0]];
    assign fifo_pndng32 = (rd32 < wr32);
    assign fifo_dout32  = mem32[rd32[3:0]];

    always @(posedge clk or posedge rst) begin
        if (rst) rd <= 0;
        else if (fifo_pop) rd <= rd + 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) rd32 <= 0;
        else if (fifo_pop32) rd32 <= rd32 + 1;
    end

    fifo_rd_serializer #(.BITS(32), .OUT_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_pndng (fifo_pndng),
        .fifo_dout  (fifo_dout),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .word_cnt   (word_cnt)
    );

    fifo_rd_serializer #(.BITS(32), .OUT_W(32)) u_dut32 (
        .clk        (clk),
        .rst        (rst),
        .fifo_pndng (fifo_pndng32),
        .fifo_dout  (fifo_dout32),
        .fifo_pop   (fifo_pop32),
        .out_valid  (out_valid32),
        .out_data   (out_data32),
        .out_ready  (out_ready),
        .out_last   (out_last32),
        .busy       (busy32),
        .word_cnt   (word_cnt32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr = 0;
        wr32 = 0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr[3:0]] = w;
        wr++;
    endtask

    task automatic push32(input logic [31:0] w);
        mem32[wr32[3:0]] = w;
        wr32++;
    endtask

    logic [7:0]  exp8 [0:7];
    logic [31:0] w32 [0:2];

    initial begin
        wr = 0;
        wr32 = 0;

        // reset held with data pending: nothing may pop or appear
        rst = 1'b1;
        out_ready = 1'b1;
        mem[0] = 32'h12345678;
        wr = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_pop",   32'(fifo_pop),  32'd0);
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_data",  32'(out_data),  32'h00);
            check("rst_last",  32'(out_last),  32'd0);
            check("rst_busy",  32'(busy),      32'd0);
            check("rst_wcnt",  32'(word_cnt),  32'd0);
        end
        do_reset();

        // single word, downstream always ready
        out_ready = 1'b1;
        push(32'hDDCCBBAA);
        #1;
        check("w1_c0_pop",   32'(fifo_pop),  32'd1);
        check("w1_c0_valid", 32'(out_valid), 32'd0);
        exp8[0] = 8'hAA; exp8[1] = 8'hBB; exp8[2] = 8'hCC; exp8[3] = 8'hDD;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("w1_valid", 32'(out_valid), 32'd1);
            check("w1_data",  32'(out_data),  32'(exp8[k-1]));
            check("w1_last",  32'(out_last),  (k == 4) ? 32'd1 : 32'd0);
            check("w1_pop",   32'(fifo_pop),  32'd0);
        end
        step();
        check("w1_c5_valid", 32'(out_valid), 32'd0);
        check("w1_c5_wcnt",  32'(word_cnt),  32'd1);
        do_reset();

        // two words back to back: second pop coincides with beat 0x44
        out_ready = 1'b1;
        push(32'h44332211);
        push(32'h88776655);
        #1;
        check("w2_c0_pop", 32'(fifo_pop), 32'd1);
        exp8[0] = 8'h11; exp8[1] = 8'h22; exp8[2] = 8'h33; exp8[3] = 8'h44;
        exp8[4] = 8'h55; exp8[5] = 8'h66; exp8[6] = 8'h77; exp8[7] = 8'h88;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("w2_valid", 32'(out_valid), 32'd1);
            check("w2_data",  32'(out_data),  32'(exp8[k-1]));
            check("w2_last",  32'(out_last),  (k == 4 || k == 8) ? 32'd1 : 32'd0);
            check("w2_pop",   32'(fifo_pop),  (k == 4) ? 32'd1 : 32'd0);
        end
        step();
        check("w2_end_valid", 32'(out_valid), 32'd0);
        check("w2_end_wcnt",  32'(word_cnt),  32'd2);
        do_reset();

        // backpressure on beat 0xBB with a second word waiting in the FIFO
        out_ready = 1'b1;
        push(32'hDDCCBBAA);
        push(32'h11111111);
        step();
        check("bp_c1_data", 32'(out_data), 32'hAA);
        step();
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_data",  32'(out_data),  32'hBB);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_last",  32'(out_last),  32'd0);
            check("bp_hold_pop",   32'(fifo_pop),  32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_bb", 32'(out_data), 32'hBB);
        step();
        check("bp_cc",      32'(out_data), 32'hCC);
        check("bp_cc_last", 32'(out_last), 32'd0);
        step();
        check("bp_dd",      32'(out_data), 32'hDD);
        check("bp_dd_last", 32'(out_last), 32'd1);
        check("bp_dd_pop",  32'(fifo_pop), 32'd1);
        step();
        check("bp_next",      32'(out_data), 32'h11);
        check("bp_next_wcnt", 32'(word_cnt), 32'd1);
        do_reset();

        // reset lands after beat 0xBB has been accepted
        out_ready = 1'b1;
        push(32'hDDCCBBAA);
        step();
        step();
        check("rm_bb", 32'(out_data), 32'hBB);
        step();
        rst = 1'b1;
        wr = 0;
        #1;
        check("rm_valid_now", 32'(out_valid), 32'd0);
        check("rm_pop_now",   32'(fifo_pop),  32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rm_valid", 32'(out_valid), 32'd0);
            check("rm_wcnt",  32'(word_cnt),  32'd0);
        end
        do_reset();

        // full-width build: one beat per word, pops on consecutive cycles
        out_ready = 1'b1;
        w32[0] = 32'hCAFE0001;
        w32[1] = 32'hBEEF0002;
        w32[2] = 32'h5A5A0003;
        push32(w32[0]);
        push32(w32[1]);
        push32(w32[2]);
        #1;
        check("b1_c0_pop", 32'(fifo_pop32), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("b1_valid", 32'(out_valid32), 32'd1);
            check("b1_last",  32'(out_last32),  32'd1);
            check("b1_data",  out_data32,       w32[k-1]);
            check("b1_pop",   32'(fifo_pop32),  (k < 3) ? 32'd1 : 32'd0);
        end
        step();
        check("b1_end_valid", 32'(out_valid32), 32'd0);
        check("b1_end_last",  32'(out_last32),  32'd0);
        check("b1_end_wcnt",  32'(word_cnt32),  32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
